// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit.
// Build option MULDIV_FAST_MUL_EN (see muldiv_unit) selects the single-cycle multiplier.
package muldiv_pkg;
    localparam int MD_ITERS = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } md_state_t;
endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step.
// acc holds {product hi, multiplier} for multiply and {unused, dividend/quotient} for divide.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic           is_div,
    input  logic [2*W-1:0] acc_i,
    input  logic [W:0]     rem_i,
    input  logic [W-1:0]   opnd,
    output logic [2*W-1:0] acc_o,
    output logic [W:0]     rem_o
);
    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W+1:0] diff;
    logic         qbit;

    always_comb begin
        sum     = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd} : '0);
        shifted = {rem_i[W-1:0], acc_i[W-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};
        qbit    = ~diff[W+1];
        acc_o   = acc_i;
        rem_o   = rem_i;
        if (is_div) begin
            // restore on borrow: keep the shifted remainder, quotient bit 0
            rem_o = qbit ? diff[W:0] : shifted;
            acc_o = {acc_i[2*W-1:W], acc_i[W-2:0], qbit};
        end else begin
            acc_o = {sum, acc_i[W-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, with MTHI/MTLO writes.
// Define MULDIV_FAST_MUL_EN to multiply in one cycle (IDLE -> FIX); divide is unaffected.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(MD_ITERS);

    md_state_t      state, state_nx;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_q;
    logic           neg_q, neg_r;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc, acc_nx;
    logic [W:0]     rem, rem_nx;
    logic [W-1:0]   a_abs, b_abs;
    logic           fast_mul;
    logic [2*W-1:0] mprod, prod_s;
    logic [W-1:0]   quo, rmd;

    always_comb begin
        a_abs = (op[0] && A[W-1]) ? -A : A;
        b_abs = (op[0] && B[W-1]) ? -B : B;
    end

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul = ~op[1];
    assign mprod    = {{W{1'b0}}, opnd} * {{W{1'b0}}, acc[W-1:0]};
`else
    assign fast_mul = 1'b0;
    assign mprod    = acc;
`endif

    muldiv_step #(.W(W)) u_step (
        .is_div (op_q[1]),
        .acc_i  (acc),
        .rem_i  (rem),
        .opnd   (opnd),
        .acc_o  (acc_nx),
        .rem_o  (rem_nx)
    );

    always_comb begin
        prod_s = neg_q ? -mprod : mprod;
        quo    = neg_q ? -acc[W-1:0] : acc[W-1:0];
        rmd    = neg_r ? -rem[W-1:0] : rem[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = fast_mul ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt == CW'(MD_ITERS - 1)) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            opnd  <= '0;
            acc   <= '0;
            rem   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        // multiply: opnd = multiplicand; divide: opnd = divisor
                        op_q  <= op;
                        neg_q <= op[0] & (A[W-1] ^ B[W-1]);
                        neg_r <= op[0] & A[W-1];
                        opnd  <= op[1] ? b_abs : a_abs;
                        acc   <= {{W{1'b0}}, (op[1] ? a_abs : b_abs)};
                        rem   <= '0;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ST_CALC: begin
                    acc <= acc_nx;
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                end
                ST_FIX: begin
                    done <= 1'b1;
                    if (op_q[1]) begin
                        hi <= rmd;
                        lo <= quo;
                    end else begin
                        hi <= prod_s[2*W-1:W];
                        lo <= prod_s[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
